// File: rtl/pipe_bist_pkg.sv
// Shared constants, operand table, reference model and FSM encoding for pipe_bist.
// The reference model wraps every intermediate at N bits, exactly like the datapath.
package pipe_bist_pkg;

    localparam int N       = 10;
    localparam int NUM_VEC = 6;
    localparam int LATENCY = 3;

    localparam int CNT_W   = $clog2(NUM_VEC + 1);
    localparam int IDX_W   = $clog2(NUM_VEC);
    localparam int DRAIN_W = $clog2(LATENCY + 2);

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] c;
        logic [N-1:0] d;
    } vec_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic vec_t mk_vec(input int a, input int b, input int c, input int d);
        vec_t v;
        v.a = N'(a);
        v.b = N'(b);
        v.c = N'(c);
        v.d = N'(d);
        return v;
    endfunction

    // Ascending range so that the first listed vector is index 0.
    localparam vec_t [0:NUM_VEC-1] DEF_TABLE = {
        mk_vec(10, 20, 12, 2),
        mk_vec(14, 15,  8, 3),
        mk_vec(18, 10, 20, 3),
        mk_vec(22,  8, 25, 4),
        mk_vec(23, 15, 40, 3),
        mk_vec(30, 30,  5, 3)
    };

    function automatic logic [N-1:0] pipe_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input logic [N-1:0] c, input logic [N-1:0] d);
        logic [N-1:0] s;
        logic [N-1:0] t;
        logic [N-1:0] u;
        s = a + b;
        t = c - d;
        u = s + t;
        return u * d;
    endfunction

endpackage

// File: rtl/pipe_bist_if.sv
// Operand/result bus between pipe_bist (master) and the pipelining datapath (slave).
// No handshake: the master presents a new operand set every cycle and f is sampled every cycle.
interface pipe_bist_if;
    import pipe_bist_pkg::*;

    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [N-1:0] d;
    logic [N-1:0] f;

    modport master (output a, b, c, d, input f);
    modport slave  (input a, b, c, d, output f);

endinterface

// File: rtl/pipe_bist_delay.sv
// Fixed-depth shift line carrying {valid, expected result}; async clear drops all in-flight entries.
module pipe_bist_delay
    import pipe_bist_pkg::*;
#(
    parameter int DEPTH = LATENCY + 1,
    parameter int W     = N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0]        valid_q;
    logic [DEPTH-1:0]        valid_d;
    logic [DEPTH-1:0][W-1:0] data_q;
    logic [DEPTH-1:0][W-1:0] data_d;

    always_comb begin
        valid_d    = {valid_q[DEPTH-2:0], in_valid};
        data_d     = data_q;
        data_d[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            data_d[i] = data_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/pipe_bist.sv
// Drives a fixed operand table into the pipelining datapath and checks each f against
// a latency-aligned expected value; reports pass, error count and first failing index.
module pipe_bist
    import pipe_bist_pkg::*;
#(
    parameter vec_t [0:NUM_VEC-1] TABLE = DEF_TABLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    pipe_bist_if.master      dp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [IDX_W-1:0] first_err_idx,
    output state_e           state_dbg
);

    state_e             state_q,      state_d;
    logic [IDX_W-1:0]   idx_q,        idx_d;
    logic [DRAIN_W-1:0] drain_q,      drain_d;
    vec_t               ops_q,        ops_d;
    logic               issued_q,     issued_d;
    logic [CNT_W-1:0]   err_q,        err_d;
    logic [IDX_W-1:0]   first_idx_q,  first_idx_d;
    logic               first_seen_q, first_seen_d;
    logic [IDX_W-1:0]   cmp_idx_q,    cmp_idx_d;
    logic               pass_q,       pass_d;
    logic               done_q,       done_d;

    logic         dly_valid;
    logic [N-1:0] dly_exp;
    logic [N-1:0] exp_in;

    // Expected value is formed from the registered operands, so it enters the line one
    // edge after issue and emerges on the same cycle the datapath presents that result.
    assign exp_in = pipe_ref(ops_q.a, ops_q.b, ops_q.c, ops_q.d);

    pipe_bist_delay #(
        .DEPTH (LATENCY + 1),
        .W     (N)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (issued_q),
        .in_data   (exp_in),
        .out_valid (dly_valid),
        .out_data  (dly_exp)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        drain_d      = drain_q;
        ops_d        = '0;
        issued_d     = 1'b0;
        err_d        = err_q;
        first_idx_d  = first_idx_q;
        first_seen_d = first_seen_q;
        cmp_idx_d    = cmp_idx_q;
        pass_d       = pass_q;
        done_d       = 1'b0;

        if (dly_valid) begin
            cmp_idx_d = cmp_idx_q + 1'b1;
            if (dly_exp != dp.f) begin
                if (err_q != CNT_W'(NUM_VEC)) begin
                    err_d = err_q + 1'b1;
                end
                if (!first_seen_q) begin
                    first_seen_d = 1'b1;
                    first_idx_d  = cmp_idx_q;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    idx_d        = '0;
                    err_d        = '0;
                    first_idx_d  = '0;
                    first_seen_d = 1'b0;
                    cmp_idx_d    = '0;
                    pass_d       = 1'b0;
                end
            end
            ST_RUN: begin
                ops_d    = TABLE[idx_q];
                issued_d = 1'b1;
                idx_d    = idx_q + 1'b1;
                if (idx_q == IDX_W'(NUM_VEC - 1)) begin
                    state_d = ST_DRAIN;
                    // Covers the datapath latency plus the operand and compare registers,
                    // so the last compare lands on the edge that enters DONE.
                    drain_d = DRAIN_W'(LATENCY + 1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            drain_q      <= '0;
            ops_q        <= '0;
            issued_q     <= 1'b0;
            err_q        <= '0;
            first_idx_q  <= '0;
            first_seen_q <= 1'b0;
            cmp_idx_q    <= '0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            drain_q      <= drain_d;
            ops_q        <= ops_d;
            issued_q     <= issued_d;
            err_q        <= err_d;
            first_idx_q  <= first_idx_d;
            first_seen_q <= first_seen_d;
            cmp_idx_q    <= cmp_idx_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
        end
    end

    assign dp.a          = ops_q.a;
    assign dp.b          = ops_q.b;
    assign dp.c          = ops_q.c;
    assign dp.d          = ops_q.d;
    assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_idx_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_pipe_bist.sv
// Directed bench for pipe_bist: two instances (default table and a wrap-around table)
// each driving a behavioural pipelining datapath with selectable fault modes.
module tb_pipe_bist;
    import pipe_bist_pkg::*;

    localparam int TA[6]    = '{10, 14, 18, 22, 23, 30};
    localparam int TB[6]    = '{20, 15, 10,  8, 15, 30};
    localparam int TC[6]    = '{12,  8, 20, 25, 40,  5};
    localparam int TD[6]    = '{ 2,  3,  3,  4,  3,  3};
    localparam int EXP_F[6] = '{80, 102, 135, 204, 225, 186};

    localparam vec_t [0:NUM_VEC-1] TBL1 = {mk_vec(0, 0, 1, 3), DEF_TABLE[1:NUM_VEC-1]};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic             start0, start1;
    logic             busy0, done0, pass0, busy1, done1, pass1;
    logic [CNT_W-1:0] err0, err1;
    logic [IDX_W-1:0] fidx0, fidx1;
    state_e           st0, st1;

    pipe_bist_if if0 ();
    pipe_bist_if if1 ();

    pipe_bist u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dp(if0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_idx(fidx0), .state_dbg(st0)
    );

    pipe_bist #(.TABLE(TBL1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dp(if1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_idx(fidx1), .state_dbg(st1)
    );

    // ---------------- datapath models ----------------
    // mode0: 0 = correct, 1 = f forced to 0 for vector 2, 2 = one extra stage of latency.
    int           mode0 = 0;
    vec_t         cap0, cap1;
    logic [N-1:0] ab0, cd0, d10, sum0, d20, prod0, late0;
    logic [N-1:0] ab1, cd1, d11, sum1, d21, prod1;
    logic [3:0]   tag0;

    always @(posedge clk) begin
        cap0  <= {if0.a, if0.b, if0.c, if0.d};
        tag0  <= {tag0[2:0], (if0.a == N'(18)) && (if0.b == N'(10))};
        ab0   <= cap0.a + cap0.b;
        cd0   <= cap0.c - cap0.d;
        d10   <= cap0.d;
        sum0  <= ab0 + cd0;
        d20   <= d10;
        prod0 <= sum0 * d20;
        late0 <= prod0;

        cap1  <= {if1.a, if1.b, if1.c, if1.d};
        ab1   <= cap1.a + cap1.b;
        cd1   <= cap1.c - cap1.d;
        d11   <= cap1.d;
        sum1  <= ab1 + cd1;
        d21   <= d11;
        prod1 <= sum1 * d21;
    end

    assign if0.f = (mode0 == 2) ? late0 : ((mode0 == 1) && tag0[3]) ? '0 : prod0;
    assign if1.f = prod1;

    // ---------------- scoreboard ----------------
    int           n_vec = 0;
    int           n_err = 0;
    logic [N-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [4*N-1:0] ops_of(input int i);
        return {N'(TA[i]), N'(TB[i]), N'(TC[i]), N'(TD[i])};
    endfunction

    // Pulses start on channel ch and returns cycles from the start edge to done (-1 on timeout).
    task automatic run_ch(input int ch, output int lat);
        if (ch == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        lat = -1;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if ((ch == 0 && done0) || (ch == 1 && done1)) begin
                lat = t;
                break;
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int           lat;
        int           ndone;
        int           dt[2];
        logic [4*N-1:0] exp_ops;
        logic [N-1:0]   exp_f;

        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_state", st0, ST_IDLE);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err", err0, 0);
        check("rst_fidx", fidx0, 0);
        check("rst_ops", {if0.a, if0.b, if0.c, if0.d}, 0);
        check("rst_state1", st1, ST_IDLE);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Correct datapath: cycle-by-cycle timeline of one run
        for (int i = 0; i < 6; i++) exp_q.push_back(N'(EXP_F[i]));
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("t0_busy", busy0, 1);
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            exp_ops = (t <= 6) ? ops_of(t - 1) : '0;
            check($sformatf("ops_t%0d", t), {if0.a, if0.b, if0.c, if0.d}, exp_ops);
            check($sformatf("busy_t%0d", t), busy0, (t <= 10));
            check($sformatf("done_t%0d", t), done0, (t == 11));
            if (t >= 5 && t <= 10) begin
                exp_f = exp_q.pop_front();
                check($sformatf("f_t%0d", t), if0.f, exp_f);
            end
            if (t == 11) begin
                check("run1_pass", pass0, 1);
                check("run1_err", err0, 0);
                check("run1_fidx", fidx0, 0);
            end
        end

        // Single corrupted result on vector 2
        mode0 = 1;
        run_ch(0, lat);
        check("v2_lat", lat, 11);
        check("v2_pass", pass0, 0);
        check("v2_err", err0, 1);
        check("v2_fidx", fidx0, 2);
        @(negedge clk);

        // Datapath one stage too slow: every compare fails, count saturates
        mode0 = 2;
        run_ch(0, lat);
        check("lat4_lat", lat, 11);
        check("lat4_pass", pass0, 0);
        check("lat4_err", err0, 6);
        check("lat4_fidx", fidx0, 0);
        @(negedge clk);
        mode0 = 0;
        repeat (2) @(negedge clk);

        // Reset in the middle of RUN, then a clean run
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", busy0, 1);
        check("mid_ops", {if0.a, if0.b, if0.c, if0.d}, ops_of(2));
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_state", st0, ST_IDLE);
        check("mrst_busy", busy0, 0);
        check("mrst_done", done0, 0);
        check("mrst_pass", pass0, 0);
        check("mrst_err", err0, 0);
        check("mrst_fidx", fidx0, 0);
        check("mrst_ops", {if0.a, if0.b, if0.c, if0.d}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_ch(0, lat);
        check("post_rst_lat", lat, 11);
        check("post_rst_pass", pass0, 1);
        check("post_rst_err", err0, 0);
        @(negedge clk);

        // Wrap-around table entry: (0+0) + (1-3 mod 1024) = 1022, times 3 mod 1024 = 1018
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        check("wrap_ops", {if1.a, if1.b, if1.c, if1.d}, {N'(0), N'(0), N'(1), N'(3)});
        repeat (4) @(negedge clk);
        check("wrap_f", if1.f, 1018);
        lat = -1;
        for (int t = 6; t <= 40; t++) begin
            @(negedge clk);
            if (done1) begin
                lat = t;
                break;
            end
        end
        check("wrap_lat", lat, 11);
        check("wrap_pass", pass1, 1);
        check("wrap_err", err1, 0);
        @(negedge clk);

        // start held high for 30 cycles: done at 11 and 24, mid-run start ignored
        ndone = 0;
        dt[0] = -1;
        dt[1] = -1;
        start0 = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (done0) begin
                if (ndone < 2) dt[ndone] = t;
                ndone++;
                check($sformatf("held_pass%0d", ndone), pass0, 1);
            end
        end
        start0 = 1'b0;
        check("held_ndone", ndone, 2);
        check("held_done0_t", dt[0], 11);
        check("held_done1_t", dt[1], 24);
        lat = -1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (st0 == ST_IDLE && !busy0) begin
                lat = t;
                break;
            end
        end
        check("held_idle_reached", (lat >= 0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
